pc_flag_sequencer: RTL and testbench
====================================

Name: pc_flag_sequencer

Overview:
- Stage directly downstream of the combinational ALU.
- Registers the ALU's carry and compare outputs (SC_OUT, BEQ, BGT) into architectural flag flops.
- Returns the registered carry to the ALU as SC_IN.
- Owns the 13-bit program counter, including sequential increment, conditional/unconditional branch and the start/halt run-control state machine. Its PC output drives both instruction fetch and the ALU PC input.

Parameters:
- PC_W, 13, program counter width in bits.
- START_ADDR, 0, PC value loaded on Start. Must be even; bit 0 is forced to 0 on load.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  single-cycle pulse; begins execution at START_ADDR.
- Halt  input  1  decoded halt; acted on only in RUN when PC[0]=1.
- BrOp  input  2  branch select: 00 none, 01 branch-if-equal, 10 branch-if-greater, 11 unconditional.
- BrTarget  input  PC_W  absolute branch target; bit 0 is ignored (forced 0).
- FlagWe  input  1  capture ALU BEQ/BGT into the flag flops.
- CarryWe  input  1  capture ALU SC_OUT into the carry flop.
- AluScOut  input  1  ALU SC_OUT.
- AluBeq  input  1  ALU BEQ.
- AluBgt  input  1  ALU BGT.
- PC  output  PC_W  current program counter.
- SC_IN  output  1  registered carry, fed to the ALU.
- BeqFlag  output  1  registered equal flag.
- BgtFlag  output  1  registered greater flag.
- Running  output  1  high in RUN.
- Done  output  1  high in HALTED.

Behaviour:
- Reset, sampled on the clock edge, has priority over everything. It sets:
  - state = IDLE
  - PC = 0
  - SC_IN = BeqFlag = BgtFlag = 0
  - Running = Done = 0
- A Reset asserted mid-RUN takes effect on the next edge, with no partial update of flags or PC.
- All outputs are registered; there is no combinational path from any input to any output.
- States:
  - IDLE: PC, flags and carry hold. Start -> RUN, with PC = START_ADDR & ~1 and SC_IN/BeqFlag/BgtFlag cleared.
  - RUN: Running = 1. PC advances as described below.
  - HALTED: Done = 1, PC frozen. Start -> RUN, with the same load as from IDLE. Halt is ignored.
- Start while in RUN is ignored.
- PC advance in RUN (each instruction occupies two PC steps; the ALU executes on odd PC):
  - PC[0]=0: PC <= PC+1. BrOp, Halt, FlagWe and CarryWe are ignored.
  - PC[0]=1, Halt=1: -> HALTED, PC holds. Branch is ignored; flag/carry writes are still captured.
  - PC[0]=1, branch taken: PC <= BrTarget & ~1. Taken when BrOp=11, or BrOp=01 and BeqFlag=1, or BrOp=10 and BgtFlag=1.
  - PC[0]=1, otherwise: PC <= PC+1.
- PC wraps modulo 2^PC_W: 0x1FFF+1 -> 0x0000.
- Flag capture happens only in RUN with PC[0]=1:
  - FlagWe=1: BeqFlag <= AluBeq, BgtFlag <= AluBgt.
  - CarryWe=1: SC_IN <= AluScOut.
  - Both may be asserted in the same cycle. Flags not written hold their value.
- Same-cycle branch and flag write: the branch decision uses the pre-edge (old) flag values. The new flags are visible to the next instruction only.
- Same-cycle Halt and branch: Halt wins.
- Same-cycle Reset and Start: Reset wins.

Test Plan:
- Reset mid-run: Reset high for 1 cycle at PC=0x0025 with flags=1 -> next cycle PC=0, all flags 0, Running=0, Done=0; a following Start with START_ADDR=0 gives PC sequence 0,1,2,3.
- Sequential increment and wrap: START_ADDR=0x1FFC, no branch/halt -> PC sequence 0x1FFC,0x1FFD,0x1FFE,0x1FFF,0x0000.
- Conditional branch: at PC=3 FlagWe=1, AluBeq=1; at PC=5 BrOp=01, BrTarget=0x0041 -> PC goes 5 -> 0x0040. Repeat with AluBeq=0 -> PC goes 5 -> 6.
- Old-flag rule: BeqFlag=0; at PC=7 BrOp=01 and FlagWe=1 with AluBeq=1 -> not taken (PC=8); BeqFlag=1 afterwards.
- Carry capture: at PC=1 CarryWe=1, AluScOut=1 -> SC_IN=1 from the next cycle. CarryWe=1 with PC[0]=0 -> SC_IN unchanged.
- Halt priority and restart: at PC=9 Halt=1, BrOp=11 -> Done=1, PC stays 9. Start -> PC=START_ADDR, Running=1, flags 0.

Source files
------------

// File: rtl/pc_flag_sequencer.sv
// Program-counter and flag sequencer sitting directly behind the combinational ALU.
//
// Registers the ALU carry/compare results into architectural flag flops.
// Returns the registered carry to the ALU.
// Owns the program counter and the IDLE/RUN/HALTED run-control machine.
// Each instruction occupies two PC steps, and the ALU executes on odd PC values.
//
// Ports:
//   CLK       - system clock, all state updates on the rising edge
//   Reset     - synchronous active-high reset, highest priority
//   Start     - single-cycle pulse, (re)starts execution at START_ADDR (IDLE/HALTED only)
//   Halt      - decoded halt, acted on in RUN on odd PC
//   BrOp      - 00 none, 01 branch-if-equal, 10 branch-if-greater, 11 unconditional
//   BrTarget  - absolute branch target, bit 0 forced to 0
//   FlagWe    - capture AluBeq/AluBgt (RUN, odd PC)
//   CarryWe   - capture AluScOut (RUN, odd PC)
//   AluScOut, AluBeq, AluBgt - ALU results
//   PC        - current program counter (fetch address and ALU PC input)
//   SC_IN     - registered carry back to the ALU
//   BeqFlag, BgtFlag - registered compare flags
//   Running   - high in RUN
//   Done      - high in HALTED
module pc_flag_sequencer #(
  parameter int unsigned PC_W       = 13,
  parameter int unsigned START_ADDR = 0
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Halt,
  input  logic [1:0]      BrOp,
  input  logic [PC_W-1:0] BrTarget,
  input  logic            FlagWe,
  input  logic            CarryWe,
  input  logic            AluScOut,
  input  logic            AluBeq,
  input  logic            AluBgt,
  output logic [PC_W-1:0] PC,
  output logic            SC_IN,
  output logic            BeqFlag,
  output logic            BgtFlag,
  output logic            Running,
  output logic            Done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_GT   = 2'b10;
  localparam logic [1:0] BR_ALL  = 2'b11;

  // Start address with the instruction-alignment bit cleared.
  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR) & ~PC_W'(1);

  state_t          state;
  logic            br_taken;
  logic [PC_W-1:0] br_pc;
  logic [PC_W-1:0] pc_inc;

  // Branch decision uses the flags as they stand before this edge, so a
  // same-cycle flag write only affects the following instruction.
  always_comb begin
    br_taken = 1'b0;
    unique case (BrOp)
      BR_NONE: br_taken = 1'b0;
      BR_EQ:   br_taken = BeqFlag;
      BR_GT:   br_taken = BgtFlag;
      BR_ALL:  br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  assign br_pc  = BrTarget & ~PC_W'(1);
  assign pc_inc = PC + PC_W'(1);  // wraps modulo 2^PC_W

  // Run-control FSM, PC and flag registers.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= ST_IDLE;
      PC      <= '0;
      SC_IN   <= 1'b0;
      BeqFlag <= 1'b0;
      BgtFlag <= 1'b0;
      Running <= 1'b0;
      Done    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_HALTED: begin
          // PC and flags hold until a Start reloads them.
          if (Start) begin
            state   <= ST_RUN;
            PC      <= START_PC;
            SC_IN   <= 1'b0;
            BeqFlag <= 1'b0;
            BgtFlag <= 1'b0;
            Running <= 1'b1;
            Done    <= 1'b0;
          end
        end

        ST_RUN: begin
          if (!PC[0]) begin
            // Fetch half of the instruction: just step.
            PC <= pc_inc;
          end else begin
            // Execute half: capture ALU results, then resolve halt/branch.
            if (CarryWe) SC_IN <= AluScOut;
            if (FlagWe) begin
              BeqFlag <= AluBeq;
              BgtFlag <= AluBgt;
            end
            if (Halt) begin
              state   <= ST_HALTED;
              Running <= 1'b0;
              Done    <= 1'b1;
            end else if (br_taken) begin
              PC <= br_pc;
            end else begin
              PC <= pc_inc;
            end
          end
        end

        default: begin
          state   <= ST_IDLE;
          Running <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_flag_sequencer.sv
module tb_pc_flag_sequencer;

  localparam int unsigned PC_W  = 13;
  localparam int          MOD   = 8192;
  localparam int          ADDR1 = 'h1FFC;

  logic            CLK;
  logic            Reset, Start, Halt, FlagWe, CarryWe, AluScOut, AluBeq, AluBgt;
  logic [1:0]      BrOp;
  logic [PC_W-1:0] BrTarget;

  logic [PC_W-1:0] pc0, pc1;
  logic sc0, beq0, bgt0, run0, done0;
  logic sc1, beq1, bgt1, run1, done1;
  logic [17:0] vec0, vec1;

  assign vec0 = {pc0, sc0, beq0, bgt0, run0, done0};
  assign vec1 = {pc1, sc1, beq1, bgt1, run1, done1};

  pc_flag_sequencer #(.PC_W(PC_W), .START_ADDR(0)) dut0 (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Halt(Halt), .BrOp(BrOp),
    .BrTarget(BrTarget), .FlagWe(FlagWe), .CarryWe(CarryWe),
    .AluScOut(AluScOut), .AluBeq(AluBeq), .AluBgt(AluBgt),
    .PC(pc0), .SC_IN(sc0), .BeqFlag(beq0), .BgtFlag(bgt0),
    .Running(run0), .Done(done0)
  );

  pc_flag_sequencer #(.PC_W(PC_W), .START_ADDR(ADDR1)) dut1 (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Halt(Halt), .BrOp(BrOp),
    .BrTarget(BrTarget), .FlagWe(FlagWe), .CarryWe(CarryWe),
    .AluScOut(AluScOut), .AluBeq(AluBeq), .AluBgt(AluBgt),
    .PC(pc1), .SC_IN(sc1), .BeqFlag(beq1), .BgtFlag(bgt1),
    .Running(run1), .Done(done1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural model: mode 0 = idle, 1 = running, 2 = halted.
  typedef struct {
    int pc;
    bit c;
    bit beq;
    bit bgt;
    int mode;
  } model_t;

  model_t m0, m1;
  int total = 0;
  int bad   = 0;

  function automatic model_t step(model_t m, int start_addr);
    model_t n = m;
    bit taken;
    if (Reset) begin
      n.pc = 0; n.c = 0; n.beq = 0; n.bgt = 0; n.mode = 0;
      return n;
    end
    if (m.mode != 1) begin
      if (Start) begin
        n.mode = 1;
        n.pc   = start_addr - (start_addr % 2);
        n.c = 0; n.beq = 0; n.bgt = 0;
      end
    end else if (m.pc % 2 == 0) begin
      n.pc = (m.pc + 1) % MOD;
    end else begin
      if (CarryWe) n.c = AluScOut;
      if (FlagWe) begin n.beq = AluBeq; n.bgt = AluBgt; end
      taken = (BrOp == 2'd3) || (BrOp == 2'd1 && m.beq) || (BrOp == 2'd2 && m.bgt);
      if (Halt)       n.mode = 2;
      else if (taken) n.pc = int'(BrTarget) - (int'(BrTarget) % 2);
      else            n.pc = (m.pc + 1) % MOD;
    end
    return n;
  endfunction

  function automatic logic [17:0] expect_vec(model_t m);
    return {PC_W'(m.pc), m.c, m.beq, m.bgt, m.mode == 1, m.mode == 2};
  endfunction

  task automatic clear_inputs();
    Reset = 0; Start = 0; Halt = 0; BrOp = 2'b00; BrTarget = '0;
    FlagWe = 0; CarryWe = 0; AluScOut = 0; AluBeq = 0; AluBgt = 0;
  endtask

  // One clock: advance models with the applied inputs, then settle past the edge.
  task automatic tick();
    model_t n0, n1;
    n0 = step(m0, 0);
    n1 = step(m1, ADDR1);
    @(posedge CLK);
    #1;
    m0 = n0;
    m1 = n1;
  endtask

  task automatic reset_and_start();
    clear_inputs(); Reset = 1; tick();
    clear_inputs(); Start = 1; tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs(); Reset = 1; tick(); tick();
    clear_inputs();
    total++;
    if (vec0 !== 18'h0) begin bad++; $display("FAIL reset_dut0 got=%h want=%h", vec0, 18'h0); end
    total++;
    if (vec1 !== 18'h0) begin bad++; $display("FAIL reset_dut1 got=%h want=%h", vec1, 18'h0); end
    // IDLE holds without Start.
    tick();
    total++;
    if (vec0 !== 18'h0) begin bad++; $display("FAIL idle_hold got=%h want=%h", vec0, 18'h0); end
  endtask

  task automatic test_reset_mid_run();
    logic [PC_W-1:0] want;
    reset_and_start();
    for (int i = 0; i < 'h25; i++) begin
      clear_inputs(); FlagWe = 1; CarryWe = 1; AluScOut = 1; AluBeq = 1; AluBgt = 1;
      tick();
    end
    clear_inputs();
    total++;
    if (vec0 !== {13'h0025, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL midrun_pre got=%h want=%h", vec0, {13'h0025, 5'b11110});
    end
    Reset = 1; tick(); clear_inputs();
    total++;
    if (vec0 !== 18'h0) begin bad++; $display("FAIL midrun_reset got=%h want=%h", vec0, 18'h0); end
    Start = 1; tick(); clear_inputs();
    for (int i = 0; i < 4; i++) begin
      want = PC_W'(i);
      total++;
      if (pc0 !== want || run0 !== 1'b1) begin
        bad++; $display("FAIL restart_seq%0d got=%h/%b want=%h/1", i, pc0, run0, want);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [PC_W-1:0] want;
    reset_and_start();
    for (int i = 0; i < 5; i++) begin
      want = PC_W'((ADDR1 + i) % MOD);
      total++;
      if (pc1 !== want || run1 !== 1'b1) begin
        bad++; $display("FAIL wrap_seq%0d got=%h/%b want=%h/1", i, pc1, run1, want);
      end
      tick();
    end
  endtask

  task automatic test_cond_branch();
    // Taken: BeqFlag set at PC=3.
    reset_and_start();
    tick(); tick(); tick();
    FlagWe = 1; AluBeq = 1; tick(); clear_inputs();
    tick();
    total++;
    if (pc0 !== 13'd5 || beq0 !== 1'b1) begin
      bad++; $display("FAIL beq_setup got=%h/%b want=0005/1", pc0, beq0);
    end
    BrOp = 2'b01; BrTarget = 13'h0041; tick(); clear_inputs();
    total++;
    if (pc0 !== 13'h0040) begin bad++; $display("FAIL beq_taken got=%h want=0040", pc0); end
    // Not taken: BeqFlag written 0.
    reset_and_start();
    tick(); tick(); tick();
    FlagWe = 1; AluBeq = 0; tick(); clear_inputs();
    tick();
    BrOp = 2'b01; BrTarget = 13'h0041; tick(); clear_inputs();
    total++;
    if (pc0 !== 13'd6) begin bad++; $display("FAIL beq_not_taken got=%h want=0006", pc0); end
    // Old-flag rule at PC=7.
    tick();
    BrOp = 2'b01; BrTarget = 13'h0100; FlagWe = 1; AluBeq = 1; tick(); clear_inputs();
    total++;
    if (pc0 !== 13'd8 || beq0 !== 1'b1) begin
      bad++; $display("FAIL old_flag got=%h/%b want=0008/1", pc0, beq0);
    end
  endtask

  task automatic test_carry_and_halt();
    reset_and_start();
    tick();
    CarryWe = 1; AluScOut = 1; tick(); clear_inputs();
    total++;
    if (pc0 !== 13'd2 || sc0 !== 1'b1) begin
      bad++; $display("FAIL carry_capture got=%h/%b want=0002/1", pc0, sc0);
    end
    CarryWe = 1; AluScOut = 0; tick(); clear_inputs();
    total++;
    if (pc0 !== 13'd3 || sc0 !== 1'b1) begin
      bad++; $display("FAIL carry_even_ignored got=%h/%b want=0003/1", pc0, sc0);
    end
    for (int i = 0; i < 6; i++) tick();
    Halt = 1; BrOp = 2'b11; BrTarget = 13'h0100; tick();
    total++;
    if (vec0 !== {13'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL halt_prio got=%h want=%h", vec0, {13'd9, 5'b10001});
    end
    tick(); clear_inputs();
    total++;
    if (vec0 !== {13'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL halt_frozen got=%h want=%h", vec0, {13'd9, 5'b10001});
    end
    Start = 1; tick(); clear_inputs();
    total++;
    if (vec0 !== {13'd0, 5'b00010}) begin
      bad++; $display("FAIL halt_restart got=%h want=%h", vec0, {13'd0, 5'b00010});
    end
    // Start while running is ignored; Reset beats Start.
    tick(); Start = 1; tick(); clear_inputs();
    total++;
    if (pc0 !== 13'd2) begin bad++; $display("FAIL start_in_run got=%h want=0002", pc0); end
    Reset = 1; Start = 1; tick(); clear_inputs();
    total++;
    if (vec0 !== 18'h0) begin bad++; $display("FAIL reset_over_start got=%h want=0", vec0); end
  endtask

  task automatic test_random();
    logic [17:0] e0, e1;
    clear_inputs(); Reset = 1; tick();
    for (int i = 0; i < 3000; i++) begin
      Reset    = ($urandom_range(0, 199) == 0);
      Start    = ($urandom_range(0, 19) == 0);
      Halt     = ($urandom_range(0, 29) == 0);
      BrOp     = 2'($urandom);
      BrTarget = PC_W'($urandom);
      FlagWe   = 1'($urandom);
      CarryWe  = 1'($urandom);
      AluScOut = 1'($urandom);
      AluBeq   = 1'($urandom);
      AluBgt   = 1'($urandom);
      tick();
      e0 = expect_vec(m0);
      e1 = expect_vec(m1);
      total++;
      if (vec0 !== e0) begin bad++; $display("FAIL rand0 cyc=%0d got=%h want=%h", i, vec0, e0); end
      total++;
      if (vec1 !== e1) begin bad++; $display("FAIL rand1 cyc=%0d got=%h want=%h", i, vec1, e1); end
    end
    clear_inputs();
  endtask

  initial begin
    m0 = '{0, 0, 0, 0, 0};
    m1 = '{0, 0, 0, 0, 0};
    clear_inputs();
    Reset = 1;
    test_reset();
    test_reset_mid_run();
    test_wrap();
    test_cond_branch();
    test_carry_and_halt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
